multicycle_sequencer: RTL

- Control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory access and register-file writeback for each instruction.
- Generates the enables for the instruction register, PC, register file write port and memory request lines.
- Consumes decoded control bits from the control unit and hit signals from the memory side; provides halt, memory-timeout error and performance counters.

---
 rtl/multicycle_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with a memory-timeout watchdog, sticky halt/error and saturating perf counters.
//
// state     | meaning
// FETCH     | instruction read outstanding, IR loads on ihit
// DECODE    | control unit decodes IR, HALT detected here
// EXECUTE   | ALU cycle, non-memory non-writeback instructions retire
// MEMORY    | data read/write outstanding until dhit
// WRITEBACK | register file write, instruction retires
// HALTED    | HALT executed, frozen until reset
// ERROR     | memory did not respond in time, frozen until reset
module multicycle_sequencer #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             rf_write,
    input  logic             halt_dec,
    output logic             iREN,
    output logic             ir_en,
    output logic             pc_en,
    output logic             dREN,
    output logic             dWEN,
    output logic             rf_WEN,
    output logic             halt,
    output logic             mem_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instr_count
);

    localparam int                WAIT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [CNT_W-1:0]  instr_q, instr_d;

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        iREN    = 1'b0;
        ir_en   = 1'b0;
        pc_en   = 1'b0;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        rf_WEN  = 1'b0;
        halt    = 1'b0;
        mem_err = 1'b0;

        // wait_d defaults to zero so any state change clears the watchdog
        case (state_q)
            ST_FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    ir_en   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = halt_dec ? ST_HALTED : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (mem_read || mem_write) begin
                    state_d = ST_MEMORY;
                end else if (rf_write) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    pc_en   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEMORY: begin
                dWEN = mem_write;
                dREN = mem_read & ~mem_write;
                if (dhit) begin
                    if (mem_write) begin
                        pc_en   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WRITEBACK: begin
                rf_WEN  = 1'b1;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALTED: begin
                halt = 1'b1;
            end
            ST_ERROR: begin
                halt    = 1'b1;
                mem_err = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        cycles_d = cycles_q;
        if ((state_q != ST_HALTED) && (state_q != ST_ERROR) && (cycles_q != CNT_MAX)) begin
            cycles_d = cycles_q + 1'b1;
        end

        instr_d = instr_q;
        if (pc_en && (instr_q != CNT_MAX)) begin
            instr_d = instr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_FETCH;
            wait_q   <= '0;
            cycles_q <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            cycles_q <= cycles_d;
            instr_q  <= instr_d;
        end
    end

    assign state       = state_q;
    assign cycles      = cycles_q;
    assign instr_count = instr_q;

endmodule
